ram_hs: RTL and testbench



---
 rtl/ram_pkg.sv | 23 ++
 rtl/ram_array.sv | 34 +++
 rtl/ram_hs.sv | 181 ++++++++++++++++++
 tb/tb_ram_hs.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: shared constants for the handshaked RAM (access formats, FSM states, port ids).
package ram_pkg;

  localparam logic [1:0] FMT_B = 2'b00;
  localparam logic [1:0] FMT_H = 2'b01;
  localparam logic [1:0] FMT_W = 2'b10;
  localparam logic [1:0] FMT_D = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic GNT_IFU = 1'b0;
  localparam logic GNT_LSU = 1'b1;

  // Access size in bytes for a format code.
  function automatic logic [3:0] fmt_bytes(input logic [1:0] fmt);
    return 4'd1 << fmt;
  endfunction

endpackage

// File: rtl/ram_array.sv
// ram_array: byte-wide storage with a byte-enable write port and a DATA_WIDTH read port.
// Byte lanes address consecutive bytes from i_addr, wrapping modulo the array size.
module ram_array #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_BYTES = 4096,
  parameter     INIT_FILE   = ""
) (
  input  logic                           clk,
  input  logic                           i_we,
  input  logic [DATA_WIDTH/8-1:0]        i_be,
  input  logic [$clog2(DEPTH_BYTES)-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0]          i_wdata,
  output logic [DATA_WIDTH-1:0]          o_rdata
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(DEPTH_BYTES);

  logic [7:0]       r_mem [DEPTH_BYTES];
  logic [IDX_W-1:0] w_idx [NB];

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign w_idx[gi]            = i_addr + IDX_W'(gi);
      assign o_rdata[8*gi +: 8]   = r_mem[w_idx[gi]];
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int k = 0; k < NB; k++) begin
      if (i_we && i_be[k]) r_mem[w_idx[k]] <= i_wdata[8*k +: 8];
    end
  end

endmodule

// File: rtl/ram_hs.sv
// ram_hs: byte-addressed RAM shared by IFU and LSU through valid/ready ports, one transaction in flight.
// Define RAM_ERR_EN for access-fault detection; without it addresses wrap and err stays 0.
module ram_hs
  import ram_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h80000000,
  parameter int                    DEPTH_BYTES = 4096,
  parameter int                    LATENCY     = 1,
  parameter                        INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0] ifu_addr,
  output logic                  ifu_resp_valid,
  input  logic                  ifu_resp_ready,
  output logic [31:0]           ifu_rdata,
  output logic                  ifu_err,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic                  lsu_we,
  input  logic [1:0]            lsu_format,
  input  logic                  lsu_unsigned,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  output logic                  lsu_resp_valid,
  input  logic                  lsu_resp_ready,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic                  lsu_err
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(DEPTH_BYTES);
  localparam int CNT_W = (LATENCY < 3) ? 1 : $clog2(LATENCY);

  state_t                  r_state, w_state_next;
  logic [CNT_W-1:0]        r_cnt, w_cnt_next;
  logic                    r_last_grant, r_gnt;
  logic [31:0]             r_ifu_rdata;
  logic [DATA_WIDTH-1:0]   r_lsu_rdata;
  logic                    r_ifu_err, r_lsu_err;

  logic                    w_idle, w_pick_lsu, w_acc_ifu, w_acc_lsu, w_acc;
  logic [1:0]              w_fmt;
  logic [3:0]              w_size;
  logic [ADDR_WIDTH-1:0]   w_addr, w_off;
  logic                    w_fault, w_we, w_msb, w_sign, w_resp_ready;
  logic [NB-1:0]           w_be;
  logic [DATA_WIDTH-1:0]   w_rd, w_ext;

  // Arbitration: a lone request wins; on a tie the port not granted last wins.
  assign w_idle        = (r_state == ST_IDLE);
  assign w_pick_lsu    = lsu_req_valid & (~ifu_req_valid | (r_last_grant == GNT_IFU));
  assign ifu_req_ready = rst_n & w_idle & ifu_req_valid & ~w_pick_lsu;
  assign lsu_req_ready = rst_n & w_idle & w_pick_lsu;
  assign w_acc_ifu     = ifu_req_valid & ifu_req_ready;
  assign w_acc_lsu     = lsu_req_valid & lsu_req_ready;
  assign w_acc         = w_acc_ifu | w_acc_lsu;

  // A doubleword on a 32-bit bus is sized as a word; the fault check flags it separately.
  assign w_fmt  = ~w_pick_lsu ? FMT_W :
                  ((lsu_format == FMT_D) && (DATA_WIDTH == 32)) ? FMT_W : lsu_format;
  assign w_size = fmt_bytes(w_fmt);
  assign w_addr = w_pick_lsu ? lsu_addr : ifu_addr;
  assign w_off  = w_addr - BASE_ADDR;

`ifdef RAM_ERR_EN
  localparam int AW1 = ADDR_WIDTH + 1;
  logic [ADDR_WIDTH:0] w_end;
  assign w_end   = {1'b0, w_off} + AW1'(w_size);
  assign w_fault = (w_addr < BASE_ADDR) | (w_end > AW1'(DEPTH_BYTES)) |
                   ((w_addr[2:0] & (w_size[2:0] - 3'd1)) != 3'd0) |
                   (w_pick_lsu & (lsu_format == FMT_D) & (DATA_WIDTH == 32));
`else
  logic w_unused_off;
  assign w_unused_off = ^w_off[ADDR_WIDTH-1:IDX_W];
  assign w_fault      = 1'b0;
`endif

  assign w_we = w_acc_lsu & lsu_we & ~w_fault;

  always_comb begin
    case (w_fmt)
      FMT_B:   w_msb = w_rd[7];
      FMT_H:   w_msb = w_rd[15];
      FMT_W:   w_msb = w_rd[31];
      default: w_msb = w_rd[DATA_WIDTH-1];
    endcase
  end
  assign w_sign = w_msb & ~lsu_unsigned;

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_be
      assign w_be[gi] = (gi < int'(w_size));
    end
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_ext
      assign w_ext[gi] = (gi < 8 * int'(w_size)) ? w_rd[gi] : w_sign;
    end
  endgenerate

  ram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_BYTES(DEPTH_BYTES),
    .INIT_FILE  (INIT_FILE)
  ) u_array (
    .clk    (clk),
    .i_we   (w_we),
    .i_be   (w_be),
    .i_addr (w_off[IDX_W-1:0]),
    .i_wdata(lsu_wdata),
    .o_rdata(w_rd)
  );

  assign w_resp_ready = (r_gnt == GNT_LSU) ? lsu_resp_ready : ifu_resp_ready;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_acc) begin
          if (LATENCY > 1) begin
            w_state_next = ST_WAIT;
            w_cnt_next   = CNT_W'(LATENCY - 1);
          end else begin
            w_state_next = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt <= CNT_W'(1)) begin
          w_state_next = ST_RESP;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      ST_RESP: if (w_resp_ready) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_last_grant <= GNT_LSU;
      r_gnt        <= GNT_LSU;
      r_ifu_rdata  <= '0;
      r_lsu_rdata  <= '0;
      r_ifu_err    <= 1'b0;
      r_lsu_err    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_acc) begin
        r_gnt        <= w_pick_lsu ? GNT_LSU : GNT_IFU;
        r_last_grant <= w_pick_lsu ? GNT_LSU : GNT_IFU;
      end
      if (w_acc_ifu) begin
        r_ifu_rdata <= w_fault ? 32'd0 : w_rd[31:0];
        r_ifu_err   <= w_fault;
      end
      // Extended load data is captured at accept; stores and faults respond with zero.
      if (w_acc_lsu) begin
        r_lsu_rdata <= (w_fault | lsu_we) ? '0 : w_ext;
        r_lsu_err   <= w_fault;
      end
    end
  end

  assign ifu_resp_valid = (r_state == ST_RESP) & (r_gnt == GNT_IFU);
  assign lsu_resp_valid = (r_state == ST_RESP) & (r_gnt == GNT_LSU);
  assign ifu_rdata      = r_ifu_rdata;
  assign lsu_rdata      = r_lsu_rdata;
  assign ifu_err        = r_ifu_err;
  assign lsu_err        = r_lsu_err;

endmodule

// File: tb/tb_ram_hs.sv
// tb_ram_hs: directed plus randomized checks of ram_hs against a byte-array reference model.
// Expectations follow RAM_ERR_EN when it is defined for the build.
module tb_ram_hs;
  localparam int          DW    = 64;
  localparam int          AW    = 32;
  localparam int          DEPTH = 4096;
  localparam int          LAT   = 3;
  localparam logic [31:0] BASE  = 32'h80000000;
`ifdef RAM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_err;
  logic [AW-1:0] ifu_addr;
  logic [31:0]   ifu_rdata;
  logic          lsu_req_valid, lsu_req_ready, lsu_we, lsu_unsigned;
  logic [1:0]    lsu_format;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata, lsu_rdata;
  logic          lsu_resp_valid, lsu_resp_ready, lsu_err;

  int checks = 0;
  int errors = 0;
  logic [7:0] mdl [DEPTH];

  always #5 clk = ~clk;

  ram_hs #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE),
    .DEPTH_BYTES(DEPTH), .LATENCY(LAT), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
    .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_we(lsu_we),
    .lsu_format(lsu_format), .lsu_unsigned(lsu_unsigned), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
    .lsu_rdata(lsu_rdata), .lsu_err(lsu_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [1:0] fmt);
    return 1 << fmt;
  endfunction

  function automatic int idx(input logic [31:0] addr, input int i);
    return int'(((addr - BASE) + 32'(i)) & 32'(DEPTH - 1));
  endfunction

  function automatic bit exp_fault(input bit is_lsu, input logic [1:0] fmt, input logic [31:0] addr);
    longint off;
    int     sz;
    bit     f;
    off = longint'(addr) - longint'(BASE);
    sz  = is_lsu ? size_of(fmt) : 4;
    f   = (off < 0) || (off + sz > DEPTH) || ((addr % sz) != 0);
    return f & ERR_EN;
  endfunction

  function automatic logic [63:0] model_load(input logic [1:0] fmt, input bit uns, input logic [31:0] addr);
    logic [63:0] v;
    int sz;
    sz = size_of(fmt);
    v  = 64'd0;
    for (int i = 0; i < sz; i++) v = v | (64'(mdl[idx(addr, i)]) << (8 * i));
    if (!uns && sz < 8 && v >= (64'd1 << (8 * sz - 1))) v = v - (64'd1 << (8 * sz));
    return v;
  endfunction

  task automatic model_store(input logic [1:0] fmt, input logic [31:0] addr, input logic [63:0] data);
    for (int i = 0; i < size_of(fmt); i++) mdl[idx(addr, i)] = data[8*i +: 8];
  endtask

  // ---------------- transactions (entered and left 1 time unit after a rising edge) ----------------
  task automatic lsu_txn(input string tag, input bit we, input logic [1:0] fmt, input bit uns,
                         input logic [31:0] addr, input logic [63:0] wdata);
    logic [63:0] exp_d;
    bit          exp_e;
    int          n;
    exp_e = exp_fault(1'b1, fmt, addr);
    exp_d = (we || exp_e) ? 64'd0 : model_load(fmt, uns, addr);
    lsu_req_valid = 1'b1; lsu_we = we; lsu_format = fmt; lsu_unsigned = uns;
    lsu_addr = addr; lsu_wdata = wdata;
    n = 0;
    while (!lsu_req_ready && n < 50) begin @(negedge clk); n++; end
    check({tag, "_accept"}, 64'(lsu_req_ready), 64'd1);
    @(posedge clk); #1;
    lsu_req_valid = 1'b0;
    if (we && !exp_e) model_store(fmt, addr, wdata);
    n = 0;
    do begin @(negedge clk); n++; end while (!lsu_resp_valid && n < 50);
    check({tag, "_lat"}, 64'(n), 64'(LAT));
    check({tag, "_rdata"}, lsu_rdata, exp_d);
    check({tag, "_err"}, 64'(lsu_err), 64'(exp_e));
    $display("lsu %s we=%0d fmt=%0d uns=%0d addr=%h rdata=%h err=%0d", tag, we, fmt, uns, addr, lsu_rdata, lsu_err);
    @(posedge clk); #1;
  endtask

  task automatic ifu_txn(input string tag, input logic [31:0] addr);
    logic [63:0] exp_d;
    bit          exp_e;
    int          n;
    exp_e = exp_fault(1'b0, 2'b10, addr);
    exp_d = exp_e ? 64'd0 : {32'd0, model_load(2'b10, 1'b1, addr)};
    ifu_req_valid = 1'b1; ifu_addr = addr;
    n = 0;
    while (!ifu_req_ready && n < 50) begin @(negedge clk); n++; end
    check({tag, "_accept"}, 64'(ifu_req_ready), 64'd1);
    @(posedge clk); #1;
    ifu_req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!ifu_resp_valid && n < 50);
    check({tag, "_lat"}, 64'(n), 64'(LAT));
    check({tag, "_rdata"}, 64'(ifu_rdata), exp_d);
    check({tag, "_err"}, 64'(ifu_err), 64'(exp_e));
    $display("ifu %s addr=%h rdata=%h err=%0d", tag, addr, ifu_rdata, ifu_err);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    logic [31:0] a;
    rst_n = 1'b0;
    ifu_req_valid = 1'b1; ifu_addr = BASE + 32'h100; ifu_resp_ready = 1'b1;
    lsu_req_valid = 1'b1; lsu_we = 1'b1; lsu_format = 2'b10; lsu_unsigned = 1'b0;
    lsu_addr = BASE + 32'h100; lsu_wdata = 64'h11223344; lsu_resp_ready = 1'b1;

    // Reset values while rst_n is low, with both requests pending
    repeat (2) @(posedge clk);
    #1;
    check("rst_ifu_req_ready", 64'(ifu_req_ready), 64'd0);
    check("rst_lsu_req_ready", 64'(lsu_req_ready), 64'd0);
    check("rst_ifu_resp_valid", 64'(ifu_resp_valid), 64'd0);
    check("rst_lsu_resp_valid", 64'(lsu_resp_valid), 64'd0);
    check("rst_ifu_rdata", 64'(ifu_rdata), 64'd0);
    check("rst_lsu_rdata", lsu_rdata, 64'd0);
    check("rst_ifu_err", 64'(ifu_err), 64'd0);
    check("rst_lsu_err", 64'(lsu_err), 64'd0);

    // Persistent tie after reset: grants alternate IFU, LSU, IFU, LSU
    model_store(2'b10, BASE + 32'h100, 64'h11223344);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (!(ifu_req_ready || lsu_req_ready) && n < 50) begin @(negedge clk); n++; end
      check($sformatf("tie%0d_lsu_ready", g), 64'(lsu_req_ready), 64'(g % 2));
      check($sformatf("tie%0d_ifu_ready", g), 64'(ifu_req_ready), 64'(1 - g % 2));
      $display("tie grant %0d: ifu_ready=%0d lsu_ready=%0d", g, ifu_req_ready, lsu_req_ready);
      @(posedge clk); #1;
      if (g == 3) begin ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; end
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!(ifu_resp_valid || lsu_resp_valid) && n < 50);
    check("tie_final_resp", 64'(lsu_resp_valid), 64'd1);
    @(posedge clk); #1;

    // Prefill a 256-byte window so every later load reads defined data
    for (int i = 0; i < 32; i++)
      lsu_txn($sformatf("fill%0d", i), 1'b1, 2'b11, 1'b0, BASE + 32'(8 * i), {$urandom, $urandom});

    // Word store, then signed and unsigned byte loads of its top byte
    lsu_txn("st_deadbeef", 1'b1, 2'b10, 1'b0, BASE + 32'h10, 64'hdeadbeef);
    lsu_txn("ld_b_signed", 1'b0, 2'b00, 1'b0, BASE + 32'h13, 64'd0);
    check("ld_b_signed_const", lsu_rdata, 64'hffffffffffffffde);
    lsu_txn("ld_b_unsigned", 1'b0, 2'b00, 1'b1, BASE + 32'h13, 64'd0);

    // Fetch latency, stall with resp_ready low, queued LSU request must not be lost
    ifu_resp_ready = 1'b0; ifu_req_valid = 1'b1; ifu_addr = BASE + 32'h10;
    n = 0;
    while (!ifu_req_ready && n < 50) begin @(negedge clk); n++; end
    check("stall_accept", 64'(ifu_req_ready), 64'd1);
    @(posedge clk); #1;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b1; lsu_we = 1'b0; lsu_format = 2'b10; lsu_unsigned = 1'b1; lsu_addr = BASE + 32'h10;
    n = 0;
    do begin @(negedge clk); n++; end while (!ifu_resp_valid && n < 50);
    check("stall_lat", 64'(n), 64'(LAT));
    for (int c = 0; c < 4; c++) begin
      check($sformatf("stall%0d_valid", c), 64'(ifu_resp_valid), 64'd1);
      check($sformatf("stall%0d_rdata", c), 64'(ifu_rdata), 64'hdeadbeef);
      check($sformatf("stall%0d_no_accept", c), 64'(lsu_req_ready), 64'd0);
      $display("stall cycle %0d: ifu_resp_valid=%0d ifu_rdata=%h", c, ifu_resp_valid, ifu_rdata);
      @(negedge clk);
    end
    ifu_resp_ready = 1'b1;
    @(posedge clk); #1;
    lsu_txn("queued_ld_w", 1'b0, 2'b10, 1'b1, BASE + 32'h10, 64'd0);

    // Doubleword store, then signed half load from its top half
    lsu_txn("st_d", 1'b1, 2'b11, 1'b0, BASE + 32'h8, 64'h0123456789abcdef);
    lsu_txn("ld_h_signed", 1'b0, 2'b01, 1'b0, BASE + 32'he, 64'd0);
    check("ld_h_signed_const", lsu_rdata, 64'h0000000000000123);

    // Boundary and alignment cases (faults when RAM_ERR_EN, wrapping/byte-wise otherwise)
    lsu_txn("ld_w_misaligned", 1'b0, 2'b10, 1'b0, BASE + 32'h2, 64'd0);
    lsu_txn("st_h_top", 1'b1, 2'b01, 1'b0, BASE + 32'hffe, 64'ha5a5);
    lsu_txn("st_w_top", 1'b1, 2'b10, 1'b0, BASE + 32'hffe, 64'h12345678);
    lsu_txn("ld_h_top", 1'b0, 2'b01, 1'b1, BASE + 32'hffe, 64'd0);
    lsu_txn("ld_w_base", 1'b0, 2'b10, 1'b1, BASE, 64'd0);

    // Randomized mix inside the prefilled window
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        ifu_txn($sformatf("rnd%0d", i), BASE + 32'($urandom_range(0, 252)));
      end else begin
        a = BASE + 32'($urandom_range(0, 247));
        lsu_txn($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), a, {$urandom, $urandom});
      end
    end

    // Asynchronous reset while a load is in WAIT
    lsu_req_valid = 1'b1; lsu_we = 1'b0; lsu_format = 2'b10; lsu_unsigned = 1'b1; lsu_addr = BASE + 32'h100;
    n = 0;
    while (!lsu_req_ready && n < 50) begin @(negedge clk); n++; end
    check("rstwait_accept", 64'(lsu_req_ready), 64'd1);
    @(posedge clk); #2;
    ifu_req_valid = 1'b1; ifu_addr = BASE;
    rst_n = 1'b0;
    #1;
    check("rstwait_ifu_req_ready", 64'(ifu_req_ready), 64'd0);
    check("rstwait_lsu_req_ready", 64'(lsu_req_ready), 64'd0);
    check("rstwait_lsu_resp_valid", 64'(lsu_resp_valid), 64'd0);
    check("rstwait_ifu_resp_valid", 64'(ifu_resp_valid), 64'd0);
    check("rstwait_lsu_rdata", lsu_rdata, 64'd0);
    check("rstwait_ifu_rdata", 64'(ifu_rdata), 64'd0);
    check("rstwait_lsu_err", 64'(lsu_err), 64'd0);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    lsu_txn("post_rst_ld_w", 1'b0, 2'b10, 1'b1, BASE + 32'h100, 64'd0);
    check("post_rst_const", lsu_rdata, 64'h11223344);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
